// File: rtl/decim_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : decim_ctrl
// Purpose  : Control FSM for a decimating filter. Counts accepted input
//            samples into frames of R samples. It drives the accumulate,
//            clear and dump strobes to the filter datapath, and holds the
//            decimated-output valid flag.
// Ports    : ACLK, ARESET         - clock, async active-high reset
//            cfg_enable           - run request (level)
//            cfg_ratio            - decimation ratio R (0 is treated as 1)
//            cfg_soft_clr         - one-cycle clear of FSM and counters
//            s_valid / s_ready    - input sample handshake
//            acc_en/acc_clr/dump  - datapath strobes (combinational)
//            m_valid / m_ready    - decimated-output handshake
//            busy                 - FSM not in IDLE
//            frame_cnt, ovf_cnt   - frames produced, overwritten results
// Option   : DECIM_CTRL_DROP_EN - no input backpressure. A dump onto an
//            untaken result overwrites it and bumps the saturating ovf_cnt.
//            When the macro is not defined, ovf_cnt reads as 0.
// Revision : 1.0 - initial release
//==============================================================================
module decim_ctrl #(
  parameter int RATIO_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               cfg_enable,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               cfg_soft_clr,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               acc_en,
  output logic               acc_clr,
  output logic               dump,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [RATIO_W-1:0] phase_q, phase_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0]   frame_q, frame_d;
  logic               m_valid_q, m_valid_d;

  logic               w_last;
  logic               w_accept;

  // Last sample of the current frame.
  assign w_last   = (phase_q == (ratio_q - RATIO_W'(1)));
  assign w_accept = s_valid && s_ready;

  always_comb begin
    s_ready = 1'b0;
    if (state_q == RUN) begin
`ifdef DECIM_CTRL_DROP_EN
      s_ready = 1'b1;
`else
      // Stall only the sample that would dump onto an untaken result.
      s_ready = !(w_last && m_valid_q && !m_ready);
`endif
    end
  end

  assign acc_en    = w_accept;
  assign acc_clr   = w_accept && (phase_q == '0);
  assign dump      = w_accept && w_last;
  assign m_valid   = m_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_q;

`ifdef DECIM_CTRL_DROP_EN
  logic [CNT_W-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (cfg_soft_clr) begin
      ovf_d = '0;
    end else if (dump && m_valid_q && !m_ready && (ovf_q != '1)) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ratio_d   = ratio_q;
    frame_d   = frame_q;
    m_valid_d = m_valid_q;

    if (cfg_soft_clr) begin
      state_d   = IDLE;
      phase_d   = '0;
      frame_d   = '0;
      m_valid_d = 1'b0;
    end else begin
      // A new dump wins over a same-cycle handoff, so valid stays high.
      if (dump) begin
        frame_d   = frame_q + CNT_W'(1);
        m_valid_d = 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cfg_enable) begin
            state_d = RUN;
            phase_d = '0;
            ratio_d = (cfg_ratio == '0) ? RATIO_W'(1) : cfg_ratio;
          end
        end
        RUN: begin
          if (!cfg_enable) begin
            // The partial frame is discarded.
            state_d = FLUSH;
            phase_d = '0;
          end else if (w_accept) begin
            phase_d = w_last ? '0 : (phase_q + RATIO_W'(1));
          end
        end
        FLUSH: begin
          if (!m_valid_q) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      ratio_q   <= RATIO_W'(1);
      frame_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ratio_q   <= ratio_d;
      frame_q   <= frame_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decim_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_decim_ctrl
// Purpose  : Directed self-checking bench for decim_ctrl. It uses immediate
//            assertions with hand-computed expectations. When the
//            DECIM_CTRL_DROP_EN macro is defined, the overwrite path is
//            checked instead of the backpressure path.
// Revision : 1.0 - initial release
//==============================================================================
module tb_decim_ctrl;

  localparam int RATIO_W = 8;
  localparam int CNT_W   = 16;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               cfg_enable;
  logic [RATIO_W-1:0] cfg_ratio;
  logic               cfg_soft_clr;
  logic               s_valid;
  logic               s_ready;
  logic               acc_en;
  logic               acc_clr;
  logic               dump;
  logic               m_valid;
  logic               m_ready;
  logic               busy;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  decim_ctrl #(.RATIO_W(RATIO_W), .CNT_W(CNT_W)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .cfg_enable  (cfg_enable),
    .cfg_ratio   (cfg_ratio),
    .cfg_soft_clr(cfg_soft_clr),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .acc_en      (acc_en),
    .acc_clr     (acc_clr),
    .dump        (dump),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESET       = 1'b1;
    cfg_enable   = 1'b0;
    cfg_ratio    = 8'd4;
    cfg_soft_clr = 1'b0;
    s_valid      = 1'b0;
    m_ready      = 1'b0;
    #1;
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_s_ready", 32'(s_ready),   32'd0);
    chk("rst_m_valid", 32'(m_valid),   32'd0);
    chk("rst_frame",   32'(frame_cnt), 32'd0);
    chk("rst_ovf",     32'(ovf_cnt),   32'd0);
    tick();
    tick();
    ARESET = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // R=4, continuous input, output always taken.
    cfg_enable = 1'b1;
    m_ready    = 1'b1;
    tick();
    chk("r4_busy", 32'(busy), 32'd1);
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("r4_s_ready", 32'(s_ready), 32'd1);
      chk("r4_acc_en",  32'(acc_en),  32'd1);
      chk("r4_acc_clr", 32'(acc_clr), 32'((i % 4) == 0));
      chk("r4_dump",    32'(dump),    32'((i % 4) == 3));
      tick();
    end
    s_valid = 1'b0;
    chk("r4_frame",   32'(frame_cnt), 32'd3);
    chk("r4_m_valid", 32'(m_valid),   32'd1);
    tick();
    chk("r4_m_taken", 32'(m_valid), 32'd0);

    // Soft clear with enable high, then re-entry with R programmed as 0.
    cfg_soft_clr = 1'b1;
    cfg_ratio    = 8'd0;
    tick();
    cfg_soft_clr = 1'b0;
    chk("sclr_busy",  32'(busy),      32'd0);
    chk("sclr_frame", 32'(frame_cnt), 32'd0);
    tick();
    chk("sclr_rerun", 32'(busy), 32'd1);
    cfg_ratio = 8'd5;  // must be ignored while running
    s_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("r0_acc_clr", 32'(acc_clr), 32'd1);
      chk("r0_dump",    32'(dump),    32'd1);
      tick();
    end
    s_valid = 1'b0;
    chk("r0_frame", 32'(frame_cnt), 32'd3);

    // Stop, then R=2 with the output not taken.
    cfg_enable = 1'b0;
    tick();
    chk("stop_flush_busy", 32'(busy),    32'd1);
    chk("stop_s_ready",    32'(s_ready), 32'd0);
    tick();
    chk("stop_idle", 32'(busy), 32'd0);
    cfg_ratio  = 8'd2;
    m_ready    = 1'b0;
    cfg_enable = 1'b1;
    tick();
    s_valid = 1'b1;
    #1;
    chk("r2_clr0", 32'(acc_clr), 32'd1);
    tick();
    chk("r2_dump1", 32'(dump), 32'd1);
    tick();
    chk("r2_m_valid", 32'(m_valid), 32'd1);
    chk("r2_s_ready_ph0", 32'(s_ready), 32'd1);
    tick();
`ifdef DECIM_CTRL_DROP_EN
    chk("drop_s_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("drop_s_ready_run", 32'(s_ready), 32'd1);
      chk("drop_dump", 32'(dump), 32'((i % 2) == 0));
      tick();
    end
    chk("drop_ovf",     32'(ovf_cnt),   32'd3);
    chk("drop_m_valid", 32'(m_valid),   32'd1);
    chk("drop_frame",   32'(frame_cnt), 32'd7);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("drop_m_taken", 32'(m_valid), 32'd0);
`else
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    chk("bp_acc_en",  32'(acc_en),  32'd0);
    chk("bp_dump",    32'(dump),    32'd0);
    tick();
    chk("bp_hold", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("bp_m_taken", 32'(m_valid),   32'd0);
    chk("bp_s_ready_back", 32'(s_ready), 32'd1);
    chk("bp_frame",   32'(frame_cnt), 32'd4);
    chk("bp_ovf",     32'(ovf_cnt),   32'd0);
`endif

    // R=8: one full frame, then enable dropped five samples into the next.
    cfg_soft_clr = 1'b1;
    cfg_enable   = 1'b0;
    tick();
    cfg_soft_clr = 1'b0;
    chk("sclr2_ovf", 32'(ovf_cnt), 32'd0);
    cfg_ratio  = 8'd8;
    cfg_enable = 1'b1;
    tick();
    s_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      #1;
      chk("r8_dump", 32'(dump), 32'(i == 7));
      tick();
    end
    s_valid    = 1'b0;
    cfg_enable = 1'b0;
    tick();
    chk("fl_busy",    32'(busy),      32'd1);
    chk("fl_m_valid", 32'(m_valid),   32'd1);
    chk("fl_frame",   32'(frame_cnt), 32'd1);
    s_valid = 1'b1;
    #1;
    chk("fl_s_ready", 32'(s_ready), 32'd0);
    chk("fl_dump",    32'(dump),    32'd0);
    tick();
    chk("fl_hold", 32'(busy), 32'd1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("fl_taken",      32'(m_valid), 32'd0);
    chk("fl_still_busy", 32'(busy),    32'd1);
    tick();
    chk("fl_idle", 32'(busy), 32'd0);
    cfg_enable = 1'b1;
    tick();
    s_valid = 1'b1;
    #1;
    chk("restart_ph0", 32'(acc_clr), 32'd1);
    chk("restart_dump", 32'(dump),   32'd0);

    // Reset at phase 3 with a pending result (R=4).
    s_valid      = 1'b0;
    cfg_soft_clr = 1'b1;
    cfg_ratio    = 8'd4;
    m_ready      = 1'b0;
    tick();
    cfg_soft_clr = 1'b0;
    tick();
    s_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    chk("arst_m_valid", 32'(m_valid),   32'd0);
    chk("arst_s_ready", 32'(s_ready),   32'd0);
    chk("arst_acc_en",  32'(acc_en),    32'd0);
    chk("arst_dump",    32'(dump),      32'd0);
    chk("arst_busy",    32'(busy),      32'd0);
    chk("arst_frame",   32'(frame_cnt), 32'd0);
    tick();
    ARESET = 1'b0;
    chk("arst_rel_idle", 32'(busy), 32'd0);
    tick();
    chk("arst_run",     32'(busy),      32'd1);
    chk("arst_run_fc",  32'(frame_cnt), 32'd0);
    chk("arst_run_clr", 32'(acc_clr),   32'd1);
    chk("arst_run_dmp", 32'(dump),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
